// File: rtl/fifo_rx_checker_pkg.sv
// fifo_rx_checker_pkg: FSM states, sequence bounds and counter width shared with the TX generator
package fifo_rx_checker_pkg;
  typedef enum logic [1:0] {IDLE, POLL, WAIT, CHECK} state_t;
  localparam logic [7:0] SEQ_FIRST = 8'h30;
  localparam logic [7:0] SEQ_LAST = 8'h7D;
  localparam int CNT_W = 16;
  function automatic logic [7:0] seq_next(input logic [7:0] x);
    return (x == SEQ_LAST) ? SEQ_FIRST : x + 8'd1;
  endfunction
endpackage

// File: rtl/fifo_rx_checker_led_stretch.sv
// fifo_rx_checker_led_stretch: retriggerable down-counter keeping an LED lit for HOLD cycles
module fifo_rx_checker_led_stretch #(
  parameter int HOLD = 3_600_000
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic trig_i,
  output logic led_o
);
  localparam int W = $clog2(HOLD + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) cnt <= '0;
    else cnt <= trig_i ? W'(HOLD) : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign led_o = cnt != '0;
endmodule

// File: rtl/fifo_rx_checker.sv
// fifo_rx_checker: polls the FIFO for bytes and checks the cyclic "0".."}" sequence.
// Define RX_ECHO_EN to echo every checked byte on tx_data_o/tx_data_rdy_o.
module fifo_rx_checker
  import fifo_rx_checker_pkg::*;
#(
  parameter int POLL_PERIOD = 877,
  parameter int RX_TIMEOUT = 255,
  parameter int LED_HOLD = 3_600_000
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  output logic             rx_poll_o,
  input  logic             rx_data_rdy_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_err_i,
  input  logic             busy_i,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic [CNT_W-1:0] seq_err_cnt_o,
  output logic             locked_o,
  output logic             led_rxerr_o,
  output logic             led_activity_o
`ifdef RX_ECHO_EN
  ,
  output logic             tx_data_rdy_o,
  output logic [7:0]       tx_data_o
`endif
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int OW = $clog2(RX_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [OW-1:0] TMO_LAST = OW'(RX_TIMEOUT);
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [OW-1:0] tmo;
  logic [7:0] rx_byte, expected;
  logic tmo_hit, in_rng, chk_ok, good_trig, err_trig;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    rx_poll_o = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE: state_nx = (timer == T_LAST) ? POLL : IDLE;
      POLL: begin
        rx_poll_o = !busy_i;
        state_nx = busy_i ? POLL : WAIT;
      end
      WAIT: begin
        tmo_hit = !rx_err_i && !rx_data_rdy_i && tmo == TMO_LAST;
        state_nx = (rx_err_i || tmo_hit) ? IDLE : rx_data_rdy_i ? CHECK : WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign in_rng = rx_byte >= SEQ_FIRST && rx_byte <= SEQ_LAST;
  assign chk_ok = in_rng && (!locked_o || rx_byte == expected);
  assign good_trig = state == CHECK && chk_ok;
  assign err_trig = (state == CHECK && !chk_ok) || tmo_hit;
  // The poll timer free-runs so poll slots stay on a fixed grid regardless of bus stalls.
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      timer <= '0;
      tmo <= '0;
      rx_byte <= '0;
      expected <= SEQ_FIRST;
      locked_o <= 1'b0;
      byte_cnt_o <= '0;
      seq_err_cnt_o <= '0;
    end else begin
      timer <= (timer == T_LAST) ? '0 : timer + 1'b1;
      tmo <= (state == WAIT) ? tmo + 1'b1 : '0;
      if (state == WAIT && rx_data_rdy_i && !rx_err_i) rx_byte <= rx_data_i;
      if (state == CHECK) begin
        locked_o <= in_rng;
        if (in_rng) expected <= seq_next(rx_byte);
      end
      if (good_trig && byte_cnt_o != '1) byte_cnt_o <= byte_cnt_o + 1'b1;
      if (err_trig && seq_err_cnt_o != '1) seq_err_cnt_o <= seq_err_cnt_o + 1'b1;
    end
  fifo_rx_checker_led_stretch #(.HOLD(LED_HOLD)) u_led_err (
    .clk_i(clk_i), .reset_ni(reset_ni), .trig_i(err_trig), .led_o(led_rxerr_o)
  );
  fifo_rx_checker_led_stretch #(.HOLD(LED_HOLD)) u_led_act (
    .clk_i(clk_i), .reset_ni(reset_ni), .trig_i(good_trig), .led_o(led_activity_o)
  );
`ifdef RX_ECHO_EN
  logic echo_pend;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      echo_pend <= 1'b0;
      tx_data_o <= '0;
    end else begin
      echo_pend <= state == CHECK;
      if (state == CHECK) tx_data_o <= rx_byte;
    end
  assign tx_data_rdy_o = echo_pend && !busy_i;
`endif
endmodule

// File: tb/tb_fifo_rx_checker.sv
// tb_fifo_rx_checker: directed polls/responses with hand-computed counter, lock and LED values
module tb_fifo_rx_checker;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic rx_poll_o, rx_data_rdy_i, rx_err_i, busy_i;
  logic [7:0] rx_data_i;
  logic [15:0] byte_cnt_o, seq_err_cnt_o;
  logic locked_o, led_rxerr_o, led_activity_o;
`ifdef RX_ECHO_EN
  logic tx_data_rdy_o;
  logic [7:0] tx_data_o;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int poll_at = 0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  fifo_rx_checker #(.POLL_PERIOD(877), .RX_TIMEOUT(255), .LED_HOLD(40)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .rx_poll_o(rx_poll_o),
    .rx_data_rdy_i(rx_data_rdy_i), .rx_data_i(rx_data_i), .rx_err_i(rx_err_i),
    .busy_i(busy_i), .byte_cnt_o(byte_cnt_o), .seq_err_cnt_o(seq_err_cnt_o),
    .locked_o(locked_o), .led_rxerr_o(led_rxerr_o), .led_activity_o(led_activity_o)
`ifdef RX_ECHO_EN
    , .tx_data_rdy_o(tx_data_rdy_o), .tx_data_o(tx_data_o)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_poll();
    int n = 0;
    while (!rx_poll_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk("poll_seen", rx_poll_o, 1);
    poll_at = cyc;
  endtask
  task automatic respond_err();
    @(negedge clk_i);
    rx_err_i = 1'b1;
    @(negedge clk_i);
    rx_err_i = 1'b0;
  endtask
  task automatic respond_data(input logic [7:0] b, input logic err);
    @(negedge clk_i);
    rx_data_i = b;
    rx_data_rdy_i = 1'b1;
    rx_err_i = err;
    @(negedge clk_i);
    rx_data_rdy_i = 1'b0;
    rx_err_i = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    wait_poll();
    respond_data(b, 1'b0);
    @(negedge clk_i);
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
  endtask
  initial begin
    int p1, n;
    logic saw;
    rx_data_rdy_i = 1'b0;
    rx_err_i = 1'b0;
    busy_i = 1'b0;
    rx_data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("rst_byte_cnt", byte_cnt_o, 0);
    chk("rst_err_cnt", seq_err_cnt_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_leds", {led_rxerr_o, led_activity_o}, 0);
    chk("rst_poll", rx_poll_o, 0);
    reset_ni = 1'b1;
    // idle bus: every poll answered with "no data"
    wait_poll();
    @(negedge clk_i);
    chk("poll_one_cycle", rx_poll_o, 0);
    respond_err();
    p1 = poll_at;
    wait_poll();
    chk("poll_period_1", poll_at - p1, 877);
    respond_err();
    p1 = poll_at;
    wait_poll();
    chk("poll_period_2", poll_at - p1, 877);
    respond_err();
    @(negedge clk_i);
    chk("idle_counts", {byte_cnt_o, seq_err_cnt_o}, 0);
    chk("idle_locked", locked_o, 0);
    chk("idle_leds", {led_rxerr_o, led_activity_o}, 0);
    // "0","1","2"
    wait_poll();
    respond_data(8'h30, 1'b0);
    chk("latency_hold", byte_cnt_o, 0);
    @(negedge clk_i);
    chk("first_byte_cnt", byte_cnt_o, 1);
    chk("first_locked", locked_o, 1);
    send_byte(8'h31);
    send_byte(8'h32);
    chk("seq3_byte_cnt", byte_cnt_o, 3);
    chk("seq3_err_cnt", seq_err_cnt_o, 0);
    chk("seq3_led_act", led_activity_o, 1);
    chk("seq3_led_err", led_rxerr_o, 0);
    // lock at "|" then wrap "}" -> "0"
    do_reset();
    chk("rst2_byte_cnt", byte_cnt_o, 0);
    send_byte(8'h7C);
    send_byte(8'h7D);
    send_byte(8'h30);
    chk("wrap_byte_cnt", byte_cnt_o, 3);
    chk("wrap_err_cnt", seq_err_cnt_o, 0);
    chk("wrap_locked", locked_o, 1);
    // expected "5", receive "7" then "8"
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    send_byte(8'h34);
    send_byte(8'h37);
    chk("mis_err_cnt", seq_err_cnt_o, 1);
    chk("mis_byte_cnt", byte_cnt_o, 7);
    chk("mis_locked", locked_o, 1);
    n = 0;
    while (led_rxerr_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("led_err_hold", n, 40);
    send_byte(8'h38);
    chk("resync_byte_cnt", byte_cnt_o, 8);
    chk("resync_err_cnt", seq_err_cnt_o, 1);
    // out-of-range byte, then a poll that never answers
    send_byte(8'h20);
    chk("oor_err_cnt", seq_err_cnt_o, 2);
    chk("oor_locked", locked_o, 0);
    chk("oor_byte_cnt", byte_cnt_o, 8);
    wait_poll();
    p1 = poll_at;
    repeat (256) @(negedge clk_i);
    chk("tmo_not_yet", seq_err_cnt_o, 2);
    @(negedge clk_i);
    chk("tmo_err_cnt", seq_err_cnt_o, 3);
    chk("tmo_led_err", led_rxerr_o, 1);
    chk("tmo_locked", locked_o, 0);
    wait_poll();
    chk("tmo_back_idle", poll_at - p1, 877);
    respond_err();
    // busy across a poll slot, then err+data together
    while (cyc < poll_at + 870) @(negedge clk_i);
    busy_i = 1'b1;
    saw = 1'b0;
    repeat (107) begin
      @(negedge clk_i);
      saw |= rx_poll_o;
    end
    chk("no_poll_busy", saw, 0);
    @(negedge clk_i);
    busy_i = 1'b0;
    #1;
    chk("poll_on_busy_fall", rx_poll_o, 1);
    respond_data(8'h39, 1'b1);
    @(negedge clk_i);
    chk("both_byte_cnt", byte_cnt_o, 8);
    chk("both_err_cnt", seq_err_cnt_o, 3);
    chk("both_locked", locked_o, 0);
    // strobe outside WAIT is ignored
    wait_poll();
    respond_err();
    repeat (5) @(negedge clk_i);
    rx_data_i = 8'h30;
    rx_data_rdy_i = 1'b1;
    @(negedge clk_i);
    rx_data_rdy_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("stray_byte_cnt", byte_cnt_o, 8);
    chk("stray_locked", locked_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
